// File: rtl/avalon_gpio_debounced_pkg.sv
// Shared constants for the debounced Avalon-MM GPIO: register map, bus widths, parameter check.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package gpio_pkg;

  localparam int ADDR_W = 3;
  localparam int BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA         = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIRECTION    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN      = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN      = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET       = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR       = 3'd7;

  // Read data appears this many clocks after the read strobe.
  localparam int READ_LATENCY = 1;

  // True when the channel count fits the 32-bit bus and the debounce window is usable.
  function automatic bit params_ok(input int data_width, input int debounce_cycles);
    return (data_width >= 1) && (data_width <= BUS_W) &&
           (debounce_cycles >= 1) && (debounce_cycles <= 65535);
  endfunction

endpackage

// File: rtl/avalon_gpio_debounced_if.sv
// Avalon-MM slave bus bundle for the GPIO port (word address, strobes, data).
// Latency: readdata valid READ_LATENCY clocks after avs_read.
// Backpressure: none; the slave never stalls, so there is no waitrequest.
interface avalon_gpio_debounced_if;

  logic [gpio_pkg::ADDR_W-1:0] avs_address;
  logic                        avs_read;
  logic                        avs_write;
  logic [gpio_pkg::BUS_W-1:0]  avs_writedata;
  logic [gpio_pkg::BUS_W-1:0]  avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/avalon_gpio_debounced_debounce_bit.sv
// One GPIO input channel: 2-flop synchroniser, hold-time debouncer, stable-edge detect.
// Latency: stable follows a pin change 2 + DEBOUNCE_CYCLES clocks later; edges one clock after that.
// Backpressure: none; free-running every clock.
module gpio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic rise_raw,
  output logic fall_raw
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive clocks the synchronised input disagrees with stable; any agreement restarts the count.
  always_comb begin
    sync1_d  = pin;
    sync2_d  = sync1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State flops; reset drops any partially counted change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable   = stable_q;
  assign rise_raw = stable_q & ~prev_q;
  assign fall_raw = ~stable_q & prev_q;

endmodule

// File: rtl/avalon_gpio_debounced.sv
// Avalon-MM GPIO: direction, output latch with set/clear, debounced inputs, edge capture, masked irq.
// Latency: readdata 1 clock after avs_read; writes visible next clock; irq 1 clock after its inputs.
// Backpressure: none; every read and write completes in a single cycle.
module avalon_gpio_debounced
  import gpio_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    DEBOUNCE_CYCLES = 1000,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  avalon_gpio_debounced_if.slave avs,
  output logic                   irq,
  input  logic [DATA_WIDTH-1:0]  gpio_in,
  output logic [DATA_WIDTH-1:0]  gpio_out,
  output logic [DATA_WIDTH-1:0]  gpio_oe
);

  if (!params_ok(DATA_WIDTH, DEBOUNCE_CYCLES) || (READ_LATENCY != 1)) begin : g_bad_params
    $error("avalon_gpio_debounced: DATA_WIDTH must be 1..32 and DEBOUNCE_CYCLES 1..65535");
  end

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [DATA_WIDTH-1:0] fall_en_q, fall_en_d;
  logic                  irq_q, irq_d;
  logic [BUS_W-1:0]      readdata_q, readdata_d;

  logic [DATA_WIDTH-1:0] wdat;
  logic [DATA_WIDTH-1:0] cap_clr;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] stable;
  logic [DATA_WIDTH-1:0] rise_raw;
  logic [DATA_WIDTH-1:0] fall_raw;

  assign wdat = avs.avs_writedata[DATA_WIDTH-1:0];

  if (DATA_WIDTH < BUS_W) begin : g_wdat_upper
    logic unused_wdat_upper;
    assign unused_wdat_upper = ^avs.avs_writedata[BUS_W-1:DATA_WIDTH];
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (gpio_in[i]),
      .stable  (stable[i]),
      .rise_raw(rise_raw[i]),
      .fall_raw(fall_raw[i])
    );
  end

  // Read mux over pre-write register values; output channels read back the latch, inputs the debounced pin.
  always_comb begin
    rd_val = '0;
    case (avs.avs_address)
      ADDR_DATA:         rd_val = (dir_q & out_q) | (~dir_q & stable);
      ADDR_DIRECTION:    rd_val = dir_q;
      ADDR_IRQ_MASK:     rd_val = mask_q;
      ADDR_EDGE_CAPTURE: rd_val = cap_q;
      ADDR_RISE_EN:      rd_val = rise_en_q;
      ADDR_FALL_EN:      rd_val = fall_en_q;
      default:           rd_val = '0;
    endcase
  end

  // Register writes, edge capture (a new edge beats a same-cycle clear), irq and held read data.
  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    cap_clr    = '0;
    if (avs.avs_write) begin
      case (avs.avs_address)
        ADDR_DATA:         out_d     = wdat;
        ADDR_DIRECTION:    dir_d     = wdat;
        ADDR_IRQ_MASK:     mask_d    = wdat;
        ADDR_EDGE_CAPTURE: cap_clr   = wdat;
        ADDR_RISE_EN:      rise_en_d = wdat;
        ADDR_FALL_EN:      fall_en_d = wdat;
        ADDR_OUTSET:       out_d     = out_q | wdat;
        ADDR_OUTCLR:       out_d     = out_q & ~wdat;
        default:           out_d     = out_q;
      endcase
    end
    cap_d      = (cap_q & ~cap_clr) | (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
    irq_d      = |(cap_q & mask_q);
    readdata_d = avs.avs_read ? BUS_W'(rd_val) : readdata_q;
  end

  // Register file flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= OUT_RESET;
      dir_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign irq              = irq_q;
  assign gpio_out         = out_q;
  assign gpio_oe          = dir_q;

endmodule

// File: tb/tb_avalon_gpio_debounced.sv
// Bench for avalon_gpio_debounced: directed scenarios plus random traffic against a behavioural model.
// Latency: reads are scored one clock after issue through an expected-value queue.
// Backpressure: none; the DUT accepts every access.
module tb_avalon_gpio_debounced;
  import gpio_pkg::*;

  localparam int          W    = 16;
  localparam int          N    = 8;
  localparam logic [15:0] OUTR = 16'h00A5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_gpio_debounced_if bus();
  avalon_gpio_debounced_if bus2();

  logic [W-1:0] gin, gout, goe;
  logic         irq;
  logic [4:0]   gin2, gout2, goe2;
  logic         irq2;

  avalon_gpio_debounced #(.DATA_WIDTH(W), .DEBOUNCE_CYCLES(N), .OUT_RESET(OUTR)) dut (
    .clk(clk), .reset_n(rst_n), .avs(bus), .irq(irq),
    .gpio_in(gin), .gpio_out(gout), .gpio_oe(goe)
  );

  avalon_gpio_debounced #(.DATA_WIDTH(5), .DEBOUNCE_CYCLES(4), .OUT_RESET(5'h0A)) dut2 (
    .clk(clk), .reset_n(rst_n), .avs(bus2), .irq(irq2),
    .gpio_in(gin2), .gpio_out(gout2), .gpio_oe(goe2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Registers per the register map; the debounced value flips once the pin, seen two
  // clocks late, has disagreed with it for N consecutive clocks.
  logic [W-1:0] m_out = OUTR, m_dir = '0, m_mask = '0, m_cap = '0, m_rise = '0, m_fall = '0;
  logic [W-1:0] m_st = '0, m_pst = '0, m_p1 = '0, m_p2 = '0;
  logic         m_irq = 1'b0;
  int           m_run [W];
  logic [W-1:0] m_edges, m_clr;

  always_comb begin
    m_clr   = '0;
    if (bus.avs_write && bus.avs_address == ADDR_EDGE_CAPTURE) m_clr = bus.avs_writedata[W-1:0];
    m_edges = (m_st & ~m_pst & m_rise) | (~m_st & m_pst & m_fall);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= OUTR; m_dir <= '0; m_mask <= '0; m_cap <= '0; m_rise <= '0; m_fall <= '0;
      m_st <= '0; m_pst <= '0; m_p1 <= '0; m_p2 <= '0; m_irq <= 1'b0;
      for (int b = 0; b < W; b++) m_run[b] <= 0;
    end else begin
      if (bus.avs_write) begin
        case (bus.avs_address)
          ADDR_DATA:      m_out  <= bus.avs_writedata[W-1:0];
          ADDR_DIRECTION: m_dir  <= bus.avs_writedata[W-1:0];
          ADDR_IRQ_MASK:  m_mask <= bus.avs_writedata[W-1:0];
          ADDR_RISE_EN:   m_rise <= bus.avs_writedata[W-1:0];
          ADDR_FALL_EN:   m_fall <= bus.avs_writedata[W-1:0];
          ADDR_OUTSET:    m_out  <= m_out | bus.avs_writedata[W-1:0];
          ADDR_OUTCLR:    m_out  <= m_out & ~bus.avs_writedata[W-1:0];
          default: ;
        endcase
      end
      m_cap <= (m_cap & ~m_clr) | m_edges;
      m_irq <= |(m_cap & m_mask);
      m_p1  <= gin;
      m_p2  <= m_p1;
      m_pst <= m_st;
      for (int b = 0; b < W; b++) begin
        if (m_p2[b] != m_st[b]) begin
          if (m_run[b] + 1 == N) begin
            m_st[b]  <= m_p2[b];
            m_run[b] <= 0;
          end else begin
            m_run[b] <= m_run[b] + 1;
          end
        end else begin
          m_run[b] <= 0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      ADDR_DATA:         return 32'((m_dir & m_out) | (~m_dir & m_st));
      ADDR_DIRECTION:    return 32'(m_dir);
      ADDR_IRQ_MASK:     return 32'(m_mask);
      ADDR_EDGE_CAPTURE: return 32'(m_cap);
      ADDR_RISE_EN:      return 32'(m_rise);
      ADDR_FALL_EN:      return 32'(m_fall);
      default:           return 32'h0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  logic [2:0]  addr_q [$];

  initial begin
    logic        rd_seen;
    logic [31:0] e;
    logic [2:0]  a;
    forever begin
      @(posedge clk);
      rd_seen = bus.avs_read;
      #2;
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected: got %h expected no read", bus.avs_readdata);
        end else begin
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          chk($sformatf("read_addr%0d", a), bus.avs_readdata, e);
        end
      end
      chk("irq_vs_model", 32'(irq), 32'(m_irq));
      chk("gpio_out_vs_model", 32'(gout), 32'(m_out));
      chk("gpio_oe_vs_model", 32'(goe), 32'(m_dir));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_op(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_read      = rd;
    bus.avs_write     = wr;
    bus.avs_writedata = d;
    if (rd) begin
      exp_q.push_back(exp_read(a));
      addr_q.push_back(a);
    end
    tick(READ_LATENCY);
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
  endtask

  task automatic bus2_op(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
    bus2.avs_address   = a;
    bus2.avs_read      = rd;
    bus2.avs_write     = wr;
    bus2.avs_writedata = d;
    tick(1);
    bus2.avs_read  = 1'b0;
    bus2.avs_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   lat;
    bit   found;
    logic glitch_seen;

    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    bus2.avs_address = '0; bus2.avs_read = 1'b0; bus2.avs_write = 1'b0; bus2.avs_writedata = '0;
    gin = '0;
    gin2 = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_out", 32'(gout), 32'h00A5);
    chk("rst_gpio_oe", 32'(goe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_readdata", bus.avs_readdata, 32'h0);
    chk("rst_gpio_out_w5", 32'(gout2), 32'h0A);
    rst_n = 1'b1;

    tick(2 + N + 2);
    bus_op(1, 0, ADDR_DATA, 0);
    chk("data_after_reset", bus.avs_readdata, 32'h0);

    // Narrow instance: upper write bits ignored, upper read bits zero
    bus2_op(0, 1, ADDR_DIRECTION, 32'h1F);
    bus2_op(0, 1, ADDR_DATA, 32'hFFFF_FFFF);
    chk("w5_gpio_out", 32'(gout2), 32'h1F);
    chk("w5_gpio_oe", 32'(goe2), 32'h1F);
    bus2_op(1, 0, ADDR_DATA, 0);
    chk("w5_read_data", bus2.avs_readdata, 32'h0000_001F);
    bus2_op(0, 1, ADDR_OUTCLR, 32'hFFFF_FFFF);
    chk("w5_outclr", 32'(gout2), 32'h0);

    // Glitch shorter than the debounce window
    bus_op(0, 1, ADDR_RISE_EN, 32'h0008);
    bus_op(0, 1, ADDR_IRQ_MASK, 32'h0008);
    glitch_seen = 1'b0;
    gin[3] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      glitch_seen |= dut.stable[3];
    end
    gin[3] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      glitch_seen |= dut.stable[3];
    end
    chk("glitch_stable", 32'(glitch_seen), 32'h0);
    bus_op(1, 0, ADDR_EDGE_CAPTURE, 0);
    chk("glitch_capture", bus.avs_readdata, 32'h0);

    // Held change: stable follows after exactly 2 + N clocks, then capture and irq
    gin[3] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (dut.stable[3]) begin
        lat = i;
        break;
      end
    end
    chk("stable_latency", 32'(lat), 32'(2 + N));
    tick(1);
    chk("irq_not_yet", 32'(irq), 32'h0);
    tick(1);
    chk("irq_asserted", 32'(irq), 32'h1);
    bus_op(1, 0, ADDR_EDGE_CAPTURE, 0);
    chk("rise_captured", bus.avs_readdata, 32'h0008);
    bus_op(0, 1, ADDR_EDGE_CAPTURE, 32'h0008);
    chk("irq_after_clear_1", 32'(irq), 32'h1);
    tick(1);
    chk("irq_after_clear_2", 32'(irq), 32'h0);

    // Fall on bit 0 coinciding with a write-1-clear of the same bit
    bus_op(0, 1, ADDR_FALL_EN, 32'h0001);
    gin[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (dut.stable[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_bit0_high", 32'(found), 32'h1);
    tick(3);
    gin[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (!dut.stable[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_bit0_low", 32'(found), 32'h1);
    bus_op(0, 1, ADDR_EDGE_CAPTURE, 32'h0001);
    bus_op(1, 0, ADDR_EDGE_CAPTURE, 0);
    chk("edge_set_wins", bus.avs_readdata, 32'h0001);
    bus_op(0, 1, ADDR_EDGE_CAPTURE, 32'h0001);

    // Output latch, set/clear and mixed-direction read
    bus_op(0, 1, ADDR_DIRECTION, 32'h00FF);
    bus_op(0, 1, ADDR_DATA, 32'h0F0F);
    bus_op(0, 1, ADDR_OUTSET, 32'h00F0);
    bus_op(0, 1, ADDR_OUTCLR, 32'h0003);
    chk("out_set_clr", 32'(gout), 32'h0FFC);
    chk("oe_direction", 32'(goe), 32'h00FF);
    gin = 16'hFF00;
    tick(2 + N + 3);
    bus_op(1, 0, ADDR_DATA, 0);
    chk("data_mixed", bus.avs_readdata, 32'h0000_FFFC);
    bus_op(1, 0, ADDR_OUTSET, 0);
    chk("outset_reads_0", bus.avs_readdata, 32'h0);
    bus_op(1, 0, ADDR_DIRECTION, 0);
    tick(3);
    chk("readdata_hold", bus.avs_readdata, 32'h0000_00FF);
    bus_op(1, 0, ADDR_OUTCLR, 0);
    chk("outclr_reads_0", bus.avs_readdata, 32'h0);

    // Read and write in the same cycle: read sees the pre-write value
    bus_op(1, 1, ADDR_DATA, 32'h1234);
    chk("rw_same_cycle", bus.avs_readdata, 32'h0000_FFFC);
    chk("rw_write_done", 32'(gout), 32'h1234);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      logic [2:0]  a;
      logic [31:0] d;
      int          op;
      if ($urandom_range(0, 15) == 0) gin = gin ^ 16'($urandom);
      op = int'($urandom_range(0, 3));
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      case (op)
        0:       tick(1);
        1:       bus_op(1, 0, a, d);
        2:       bus_op(0, 1, a, d);
        default: bus_op(1, 1, a, d);
      endcase
    end

    // Reset in the middle of a debounce
    gin = ~gin;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_readdata", bus.avs_readdata, 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_gpio_out", 32'(gout), 32'h00A5);
    chk("midrst_stable", 32'(dut.stable), 32'h0);
    tick(2);
    rst_n = 1'b1;
    bus_op(1, 0, ADDR_DATA, 0);
    bus_op(1, 0, ADDR_EDGE_CAPTURE, 0);
    tick(2 + N + 3);
    bus_op(1, 0, ADDR_DATA, 0);

    tick(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_gpio_debounced.md
Name: avalon_gpio_debounced

Overview:
- Parametrised Avalon-MM GPIO port; successor to the fixed-width PIO peripherals on the system interconnect (LEDs, slider switches, pushbuttons, JP1/Arduino headers).
- Adds per-bit direction control, a two-flop synchroniser and per-bit debouncer on inputs, per-bit rising/falling edge capture, maskable interrupt, and atomic set/clear of output bits.
- Sits between the interconnect and board pins; the top-level instantiates the tri-state buffer.

Parameters:
- DATA_WIDTH, 16, number of GPIO channels, legal 1..32.
- DEBOUNCE_CYCLES, 1000, clocks a synchronised input must hold a new value before it is accepted, legal 1..65535.
- OUT_RESET, 0, DATA_WIDTH-bit reset value of the output latch.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; all flops clear on assertion.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data; bits above DATA_WIDTH are ignored.
- avs_readdata  out  32  read data, fixed read latency 1; bits above DATA_WIDTH read 0.
- irq  out  1  level interrupt.
- gpio_in  in  DATA_WIDTH  asynchronous pin inputs.
- gpio_out  out  DATA_WIDTH  output latch.
- gpio_oe  out  DATA_WIDTH  per-bit output enable (equals DIRECTION).

Behaviour:
- Register map:
  - 0 DATA: read = (dir & out_latch) | (~dir & stable); write loads out_latch.
  - 1 DIRECTION: 1 = output.
  - 2 IRQ_MASK.
  - 3 EDGE_CAPTURE: read; writing 1 to a bit clears it.
  - 4 RISE_EN.
  - 5 FALL_EN.
  - 6 OUTSET: write-1-sets bits of out_latch; reads 0.
  - 7 OUTCLR: write-1-clears bits of out_latch; reads 0.
- Reset values:
  - out_latch = OUT_RESET.
  - DIRECTION, IRQ_MASK, EDGE_CAPTURE, RISE_EN, FALL_EN = 0.
  - avs_readdata = 0; irq = 0.
  - sync flops, stable, prev_stable and counters = 0.
- Read: avs_readdata is registered; it shows the addressed register the cycle after avs_read. It holds its value when no read is issued. Reads have no side effects.
- Write: takes effect at the clock edge where avs_write is high; visible on the pins and to a read issued the next cycle. avs_read and avs_write in the same cycle: write performed, readdata reflects pre-write value.
- Synchroniser: two flops per bit; sync = second stage.
- Debounce, per bit:
  - If sync == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Else: counter++.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never changes stable.
  - Latency from pin change to stable change is 2 + DEBOUNCE_CYCLES clocks.
  - Counter width = clog2(DEBOUNCE_CYCLES)+1, saturation not needed.
- Edge detect: prev_stable <= stable every cycle.
  - rise = stable & ~prev_stable & RISE_EN; fall = ~stable & prev_stable & FALL_EN.
  - EDGE_CAPTURE bit sets the cycle after the stable transition.
  - Edges are captured regardless of DIRECTION and IRQ_MASK.
- Same-cycle edge and write-1-clear on the same bit: set wins; the bit stays 1.
- Stable resets to 0, so an input held high through reset produces one rising edge 2 + DEBOUNCE_CYCLES clocks after release (if RISE_EN is set by then).
- irq = registered OR of (EDGE_CAPTURE & IRQ_MASK); updates one cycle after either operand changes. It stays asserted until software clears the captured bits or masks them.
- Reset mid-debounce: counter, stable and capture clear immediately (asynchronous); there is no partial state on release.
- DIRECTION change does not disturb out_latch or the debouncer.

Decomposition:
- gpio_pkg:
  - register address constants ADDR_DATA..ADDR_OUTCLR.
  - read-latency constant.
  - width-check function that asserts 1 <= DATA_WIDTH <= 32 and DEBOUNCE_CYCLES >= 1 at elaboration.
- Sub-module gpio_debounce_bit:
  - contains the synchroniser, counter, stable and prev_stable for one bit.
  - parameter DEBOUNCE_CYCLES.
  - outputs stable, rise_raw and fall_raw.
  - instantiated DATA_WIDTH times in a generate loop.
- Top-level holds the register file, read mux and irq flop.

Test Plan:
- Reset with OUT_RESET=16'h00A5 -> gpio_out=00A5, gpio_oe=0, irq=0; read DATA with gpio_in=0 after 2+DEBOUNCE_CYCLES clocks -> 0.
- DEBOUNCE_CYCLES=8: pulse gpio_in[3] high for 7 clocks -> stable never changes, EDGE_CAPTURE=0. Then hold it high 8+ clocks -> stable[3] rises exactly 10 clocks after the pin edge.
- RISE_EN=0x0008, IRQ_MASK=0x0008, debounced rise on bit 3 -> EDGE_CAPTURE=0x0008, irq=1 one cycle later. Write 0x0008 to EDGE_CAPTURE -> irq=0 two cycles later.
- FALL_EN=0x0001, write-1-clear of bit 0 in the same cycle its fall is detected -> EDGE_CAPTURE[0] remains 1.
- DIRECTION=0x00FF, write DATA=0x0F0F, OUTSET=0x00F0, OUTCLR=0x0003 -> gpio_out=0x0FFC. Read DATA with gpio_in=0xFF00 debounced -> 0xFFFC. Reads of OUTSET/OUTCLR return 0.
- DATA_WIDTH=5: write DATA=0xFFFFFFFF with DIRECTION=0x1F -> gpio_out=5'h1F, readdata=0x0000001F.
